alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter and sequencer that shares the single 32-bit combinational ALU (4-bit opcode select, result plus zero flag) between two requesters, e.g. the main datapath and a secondary address/branch unit. It accepts a request over a req/gnt handshake, registers the operands, drives the ALU for one cycle, and returns the registered result, zero flag and error status with a one-cycle done pulse. Illegal operations (divide or modulo by zero, undefined opcode 4'b1010) are trapped before reaching the ALU.

## Interface
- WIDTH, 32, operand/result width (ALU width; fixed at 32 in this design)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  1  request; held high with stable opN/aN/bN until gntN seen
- op0, op1  in  4  ALU opcode (ALU encoding)
- a0, b0, a1, b1  in  32  operands
- gnt0, gnt1  out  1  one-cycle grant pulse; operands latched on the same edge
- done0, done1  out  1  one-cycle pulse; res/zf/err valid this cycle
- res  out  32  registered result, held until the next done
- zf  out  1  registered ALU zero flag
- err  out  1  operation trapped (no ALU use)
- alu_a, alu_b  out  32  ALU operand drive
- alu_sel  out  4  ALU opcode drive
- alu_res  in  32  ALU result
- alu_zf  in  1  ALU zero flag

## Operation
- States: IDLE, EXEC, RESP. Per-request owner register own and round-robin pointer last.
- IDLE/RESP: if any req sampled high at the edge, grant one, latch op/a/b, set own, pulse gnt(own), go EXEC; else go/stay IDLE.
- Arbitration: single request wins; both high -> requester not equal to last wins; last updated to winner on each grant.
- EXEC: alu_a/alu_b/alu_sel driven from latched registers (unless trapped); at edge capture alu_res->res, alu_zf->zf, err=0; go RESP.
- Trap: latched op 4'b0011 or 4'b1000 with b==0, or op 4'b1010 -> alu_sel held at 4'b1111, alu_a/alu_b 0; at EXEC edge res=0, zf=0, err=1.
- RESP: done(own)=1 for exactly this cycle; res/zf/err stable until next RESP.
- Outside EXEC: alu_a=0, alu_b=0, alu_sel=4'b1111.
- gnt and done never asserted for both ports in the same cycle; done only to the port that received the matching gnt.
- Requester must drop req before the edge following its gnt; a req still high at the RESP edge is a new request.

## Timing
- Reset values: state IDLE, last=1 (port 0 wins first tie), own=0, gnt0/gnt1/done0/done1=0, res=0, zf=0, err=0, alu_a=alu_b=0, alu_sel=4'b1111.
- req high at edge E0 -> gnt high cycle E0..E1, ALU driven E0..E1 -> done/res valid E1..E2.
- Latency req-sample to done: 2 cycles. Throughput: one operation per 2 cycles with back-to-back requests (RESP grants directly).
- Reset asserted mid-EXEC or mid-RESP: operation discarded, no done, all outputs to reset values immediately (async).
- req arriving during EXEC is not sampled until the RESP edge.
- No combinational path from req*/op*/a*/b* to any output.

## Test plan
- Single op: req0, op=4'b0010, a0=5, b0=7 -> gnt0 1 cycle later, done0 2 cycles after sample, res=12, zf=0, err=0.
- Zero flag: req1, op=4'b0110, a1=b1=0x1234 -> done1, res=0, zf=1, err=0; alu_sel=4'b0110 only during EXEC.
- Tie and fairness: req0 and req1 both held continuously after reset -> grant order 0,1,0,1; done every 2 cycles; results match each port's operands.
- Trap: op=4'b1000, b=0 -> alu_sel stays 4'b1111, done with res=0, zf=0, err=1; same for op=4'b1010 with b=3.
- Reset mid-op: assert rst during EXEC of an add -> no done pulse, res=0, alu_sel=4'b1111; after release, req1 alone -> granted normally.
- Back-to-back: req0 op=4'b0101 a=6 b=7, then req0 re-raised at RESP with op=4'b1110 b=1 -> res=42 then res=0x00010000, done0 2 cycles apart.

Source files
------------

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two-port round-robin arbiter/sequencer sharing one 32-bit ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [3:0]       op0,
    input  logic [3:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res,
    output logic             zf,
    output logic             err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zf
);

    localparam logic [3:0] SEL_IDLE = 4'b1111;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_MOD   = 4'b1000;
    localparam logic [3:0] OP_BAD   = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             own;
    logic             last;
    logic             win;
    logic             take;
    logic             trap;
    logic [3:0]       op_l;
    logic [WIDTH-1:0] a_l;
    logic [WIDTH-1:0] b_l;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        take       = 1'b0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_sel    = SEL_IDLE;

        // On a tie the port that did not win last time gets the grant.
        if (req0 && req1) begin
            win = ~last;
        end else begin
            win = req1;
        end

        trap = (op_l == OP_BAD) ||
               (((op_l == OP_DIV) || (op_l == OP_MOD)) && (b_l == '0));

        case (state)
            IDLE, RESP: begin
                if (req0 || req1) begin
                    take       = 1'b1;
                    next_state = EXEC;
                end else begin
                    next_state = IDLE;
                end
                if (state == RESP) begin
                    done0 = ~own;
                    done1 = own;
                end
            end
            EXEC: begin
                next_state = RESP;
                gnt0       = ~own;
                gnt1       = own;
                if (!trap) begin
                    alu_a   = a_l;
                    alu_b   = b_l;
                    alu_sel = op_l;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own  <= 1'b0;
            last <= 1'b1;
            op_l <= '0;
            a_l  <= '0;
            b_l  <= '0;
            res  <= '0;
            zf   <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (take) begin
                own  <= win;
                last <= win;
                if (win) begin
                    op_l <= op1;
                    a_l  <= a1;
                    b_l  <= b1;
                end else begin
                    op_l <= op0;
                    a_l  <= a0;
                    b_l  <= b0;
                end
            end
            if (state == EXEC) begin
                if (trap) begin
                    res <= '0;
                    zf  <= 1'b0;
                    err <= 1'b1;
                end else begin
                    res <= alu_res;
                    zf  <= alu_zf;
                    err <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed self-checking bench for alu_arbiter with a behavioural ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [3:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1;
    logic [31:0] res;
    logic        zf, err;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [31:0] alu_res;
    logic        alu_zf;

    int tests;
    int fails;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .res(res), .zf(zf), .err(err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_res(alu_res), .alu_zf(alu_zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; an idle select yields a marker value so untrapped use shows up.
    function automatic logic [31:0] alu_f(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
        case (s)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0011: return (y == 0) ? 32'hBAD0_0000 : x / y;
            4'b0101: return x * y;
            4'b0110: return x - y;
            4'b1000: return (y == 0) ? 32'hBAD0_0001 : x % y;
            4'b1110: return y << 16;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb begin
        alu_res = alu_f(alu_sel, alu_a, alu_b);
        alu_zf  = (alu_res == 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_handshake: got %b want 0000", {gnt0, gnt1, done0, done1});
        end
        tests++;
        if ({res, zf, err} !== 34'd0) begin
            fails++;
            $display("FAIL reset_result: got res=%h zf=%b err=%b want 0/0/0", res, zf, err);
        end
        tests++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_sel !== 4'b1111) begin
            fails++;
            $display("FAIL reset_alu: got a=%h b=%h sel=%b want 0/0/1111", alu_a, alu_b, alu_sel);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single();
        req0 = 1'b1; op0 = 4'b0010; a0 = 32'd5; b0 = 32'd7;
        tick();
        req0 = 1'b0;
        tests++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || done0 !== 1'b0) begin
            fails++;
            $display("FAIL single_gnt: got gnt0=%b gnt1=%b done0=%b want 1/0/0", gnt0, gnt1, done0);
        end
        tests++;
        if (alu_sel !== 4'b0010 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
            fails++;
            $display("FAIL single_alu: got sel=%b a=%0d b=%0d want 0010/5/7", alu_sel, alu_a, alu_b);
        end
        tick();
        tests++;
        if (done0 !== 1'b1 || done1 !== 1'b0 || gnt0 !== 1'b0 || res !== 32'd12 || zf !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL single_done: got done0=%b done1=%b gnt0=%b res=%0d zf=%b err=%b want 1/0/0/12/0/0",
                     done0, done1, gnt0, res, zf, err);
        end
        tests++;
        if (alu_sel !== 4'b1111) begin
            fails++;
            $display("FAIL single_resp_sel: got %b want 1111", alu_sel);
        end
        tick();
        tests++;
        if (done0 !== 1'b0 || gnt0 !== 1'b0 || res !== 32'd12) begin
            fails++;
            $display("FAIL single_idle: got done0=%b gnt0=%b res=%0d want 0/0/12", done0, gnt0, res);
        end
    endtask

    task automatic test_zero();
        req1 = 1'b1; op1 = 4'b0110; a1 = 32'h1234; b1 = 32'h1234;
        tests++;
        if (alu_sel !== 4'b1111) begin
            fails++;
            $display("FAIL zero_pre_sel: got %b want 1111", alu_sel);
        end
        tick();
        req1 = 1'b0;
        tests++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || alu_sel !== 4'b0110) begin
            fails++;
            $display("FAIL zero_gnt: got gnt1=%b gnt0=%b sel=%b want 1/0/0110", gnt1, gnt0, alu_sel);
        end
        tick();
        tests++;
        if (done1 !== 1'b1 || done0 !== 1'b0 || res !== 32'd0 || zf !== 1'b1 || err !== 1'b0 || alu_sel !== 4'b1111) begin
            fails++;
            $display("FAIL zero_done: got done1=%b done0=%b res=%h zf=%b err=%b sel=%b want 1/0/0/1/0/1111",
                     done1, done0, res, zf, err, alu_sel);
        end
        tick();
    endtask

    task automatic test_tie();
        logic        exp_port;
        logic [31:0] exp_res;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; op0 = 4'b0010; a0 = 32'd1;  b0 = 32'd2;
        req1 = 1'b1; op1 = 4'b0110; a1 = 32'd10; b1 = 32'd3;
        for (int k = 0; k < 4; k++) begin
            exp_port = k[0];
            exp_res  = exp_port ? 32'd7 : 32'd3;
            tick();
            tests++;
            if (gnt0 !== ~exp_port || gnt1 !== exp_port) begin
                fails++;
                $display("FAIL tie_gnt%0d: got gnt0=%b gnt1=%b want port %0d", k, gnt0, gnt1, exp_port);
            end
            tick();
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tests++;
            if (done0 !== ~exp_port || done1 !== exp_port || res !== exp_res) begin
                fails++;
                $display("FAIL tie_done%0d: got done0=%b done1=%b res=%0d want port %0d res %0d",
                         k, done0, done1, res, exp_port, exp_res);
            end
        end
        tick();
        tests++;
        if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin
            fails++;
            $display("FAIL tie_idle: got %b want 0000", {gnt0, gnt1, done0, done1});
        end
    endtask

    task automatic test_trap();
        req0 = 1'b1; op0 = 4'b1000; a0 = 32'd9; b0 = 32'd0;
        tick();
        req0 = 1'b0;
        tests++;
        if (gnt0 !== 1'b1 || alu_sel !== 4'b1111 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            fails++;
            $display("FAIL trap_mod_alu: got gnt0=%b sel=%b a=%h b=%h want 1/1111/0/0", gnt0, alu_sel, alu_a, alu_b);
        end
        tick();
        tests++;
        if (done0 !== 1'b1 || res !== 32'd0 || zf !== 1'b0 || err !== 1'b1) begin
            fails++;
            $display("FAIL trap_mod_done: got done0=%b res=%h zf=%b err=%b want 1/0/0/1", done0, res, zf, err);
        end
        req1 = 1'b1; op1 = 4'b1010; a1 = 32'd4; b1 = 32'd3;
        tick();
        req1 = 1'b0;
        tests++;
        if (gnt1 !== 1'b1 || alu_sel !== 4'b1111 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            fails++;
            $display("FAIL trap_undef_alu: got gnt1=%b sel=%b a=%h b=%h want 1/1111/0/0", gnt1, alu_sel, alu_a, alu_b);
        end
        tick();
        tests++;
        if (done1 !== 1'b1 || done0 !== 1'b0 || res !== 32'd0 || zf !== 1'b0 || err !== 1'b1) begin
            fails++;
            $display("FAIL trap_undef_done: got done1=%b done0=%b res=%h zf=%b err=%b want 1/0/0/0/1",
                     done1, done0, res, zf, err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        req0 = 1'b1; op0 = 4'b0101; a0 = 32'd6; b0 = 32'd7;
        tick();
        req0 = 1'b0;
        tests++;
        if (gnt0 !== 1'b1 || alu_sel !== 4'b0101) begin
            fails++;
            $display("FAIL b2b_gnt1: got gnt0=%b sel=%b want 1/0101", gnt0, alu_sel);
        end
        tick();
        tests++;
        if (done0 !== 1'b1 || res !== 32'd42 || err !== 1'b0) begin
            fails++;
            $display("FAIL b2b_done1: got done0=%b res=%0d err=%b want 1/42/0", done0, res, err);
        end
        req0 = 1'b1; op0 = 4'b1110; a0 = 32'd0; b0 = 32'd1;
        tick();
        req0 = 1'b0;
        tests++;
        if (gnt0 !== 1'b1 || done0 !== 1'b0 || alu_sel !== 4'b1110) begin
            fails++;
            $display("FAIL b2b_gnt2: got gnt0=%b done0=%b sel=%b want 1/0/1110", gnt0, done0, alu_sel);
        end
        tick();
        tests++;
        if (done0 !== 1'b1 || res !== 32'h0001_0000 || zf !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL b2b_done2: got done0=%b res=%h zf=%b err=%b want 1/00010000/0/0", done0, res, zf, err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen_done;
        seen_done = 0;
        req0 = 1'b1; op0 = 4'b0010; a0 = 32'd3; b0 = 32'd4;
        tick();
        req0 = 1'b0;
        tests++;
        if (gnt0 !== 1'b1) begin
            fails++;
            $display("FAIL rmid_gnt: got gnt0=%b want 1", gnt0);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (gnt0 !== 1'b0 || alu_sel !== 4'b1111 || alu_a !== 32'd0 || res !== 32'd0) begin
            fails++;
            $display("FAIL rmid_async: got gnt0=%b sel=%b a=%h res=%h want 0/1111/0/0", gnt0, alu_sel, alu_a, res);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done0 || done1) seen_done++;
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        if (done0 || done1) seen_done++;
        tests++;
        if (seen_done !== 0 || res !== 32'd0) begin
            fails++;
            $display("FAIL rmid_nodone: got done pulses=%0d res=%h want 0/0", seen_done, res);
        end
        req1 = 1'b1; op1 = 4'b0010; a1 = 32'd1; b1 = 32'd1;
        tick();
        req1 = 1'b0;
        tests++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            fails++;
            $display("FAIL rmid_regrant: got gnt1=%b gnt0=%b want 1/0", gnt1, gnt0);
        end
        tick();
        tests++;
        if (done1 !== 1'b1 || res !== 32'd2) begin
            fails++;
            $display("FAIL rmid_done: got done1=%b res=%0d want 1/2", done1, res);
        end
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst  = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0  = 4'd0; op1  = 4'd0;
        a0   = 32'd0; b0  = 32'd0; a1 = 32'd0; b1 = 32'd0;
        test_reset();
        test_single();
        test_zero();
        test_trap();
        test_back_to_back();
        test_reset_mid();
        test_tie();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
